// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART constants (data width, MMIO status bit positions)
//                and sizing helpers used by the receiver, transmitter, decoder
//                and receive FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W = 8;

    localparam int STAT_VALID  = 0;
    localparam int STAT_OVF    = 1;
    localparam int STAT_IRQ    = 2;

    // Width of a fill-level counter that must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_if
//  Description : Receiver-side handshake and CPU-side pop/status bundle for
//                the UART receive FIFO. slave = FIFO, master = its neighbours.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
);
    logic [UART_DATA_W-1:0]  rx_data_i;
    logic                    rx_ready_i;
    logic                    rx_read_o;
    logic                    cpu_rd_i;
    logic [UART_DATA_W-1:0]  cpu_data_o;
    logic                    cpu_valid_o;
    logic [cnt_w(DEPTH)-1:0] count_o;
    logic                    overflow_o;
    logic                    ovf_clr_i;
    logic                    irq_o;

    modport slave (
        input  rx_data_i,
        input  rx_ready_i,
        output rx_read_o,
        input  cpu_rd_i,
        output cpu_data_o,
        output cpu_valid_o,
        output count_o,
        output overflow_o,
        input  ovf_clr_i,
        output irq_o
    );

    modport master (
        output rx_data_i,
        output rx_ready_i,
        input  rx_read_o,
        output cpu_rd_i,
        input  cpu_data_o,
        input  cpu_valid_o,
        input  count_o,
        input  overflow_o,
        output ovf_clr_i,
        input  irq_o
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_mem
//  Description : DEPTH x WIDTH register array, one synchronous write port and
//                one asynchronous read port. Contents are never reset.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     i_wr_en,
    input  wire logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  wire logic [WIDTH-1:0]         i_wr_data,
    input  wire logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic      [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Receive buffer behind the UART receiver: drains each byte into
//                a DEPTH-entry circular FIFO with show-ahead CPU pop, fill
//                count and sticky overflow. Optional fill-level interrupt is
//                built when UART_RX_FIFO_IRQ_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int IRQ_LEVEL = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    uart_rx_fifo_if.slave     bus
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = cnt_w(DEPTH);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic                   r_overflow;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_ovf_next;
    logic [c_CNT_W-1:0]     w_count_next;
    logic [UART_DATA_W-1:0] w_rd_data;

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);

    // Full with a simultaneous pop frees a slot in the same edge, so the push lands.
    assign w_pop      = bus.cpu_rd_i & ~w_empty;
    assign w_push     = bus.rx_ready_i & (~w_full | w_pop);
    assign w_drop     = bus.rx_ready_i & w_full & ~w_pop;
    assign w_ovf_next = w_drop | (r_overflow & ~bus.ovf_clr_i);

    // The receiver is always acknowledged, even on a drop or in reset, so its flag clears.
    assign bus.rx_read_o = bus.rx_ready_i;

    always_comb begin
        w_count_next = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count    <= w_count_next;
            r_overflow <= w_ovf_next;
        end
    end

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.rx_data_i),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    assign bus.cpu_data_o  = w_empty ? '0 : w_rd_data;
    assign bus.cpu_valid_o = ~w_empty;
    assign bus.count_o     = r_count;
    assign bus.overflow_o  = r_overflow;

`ifdef UART_RX_FIFO_IRQ_EN
    localparam logic [c_CNT_W-1:0] c_IRQ_LVL = c_CNT_W'(IRQ_LEVEL);

    logic r_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (w_count_next >= c_IRQ_LVL) | w_ovf_next;
        end
    end

    assign bus.irq_o = r_irq;
`else
    logic [31:0] w_unused_irq_level;
    assign w_unused_irq_level = 32'(IRQ_LEVEL);
    assign bus.irq_o          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. It drains each completed byte from the receiver's ready/data/read-enable handshake into a DEPTH-entry circular FIFO. It presents a show-ahead pop interface and status (count, valid, sticky overflow) to the CPU MMIO decoder. This decouples CPU polling latency from line rate, so back-to-back bytes at 115200 baud are not lost.

Parameters:
DEPTH, 16, number of FIFO entries; power of two, minimum 2.
IRQ_LEVEL, 8, fill level at or above which irq_o asserts (optional feature); 1..DEPTH.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous reset, active-high.
rx_data_i  input  8  byte from UART receiver; stable while rx_ready_i is high.
rx_ready_i  input  1  receiver byte-ready level flag; held high until acknowledged.
rx_read_o  output  1  acknowledge to receiver (its read enable); combinational.
cpu_rd_i  input  1  CPU pop strobe, one cycle per byte.
cpu_data_o  output  8  head entry (show-ahead); 0 when empty.
cpu_valid_o  output  1  FIFO non-empty.
count_o  output  $clog2(DEPTH)+1  current fill level.
overflow_o  output  1  sticky: a byte was dropped because the FIFO was full.
ovf_clr_i  input  1  clears overflow_o.
irq_o  output  1  fill-level interrupt.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: wr_ptr=0, rd_ptr=0, count=0, overflow_o=0, irq_o=0, cpu_valid_o=0, cpu_data_o=0. Storage contents are not reset. rx_read_o follows rx_ready_i even during reset, so a stale receiver flag is flushed.
- Push: rx_read_o = rx_ready_i. On each clk edge with rx_ready_i=1, one push is attempted. The receiver drops ready the next cycle, so one byte gives exactly one push. The block does not edge-detect.
- Push accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle. On accept: mem[wr_ptr]<=rx_data_i; wr_ptr<=wr_ptr+1, wrapping modulo DEPTH.
- Push when full with no pop: byte discarded, rx_read_o still asserted (receiver must be cleared), overflow_o<=1, pointers and count unchanged.
- Pop: effective when cpu_rd_i=1 and count>0; rd_ptr<=rd_ptr+1 (wrap). Pop on empty is ignored, with no error flag.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds DEPTH and never underflows.
- Empty with push and pop in the same cycle: pop ignored, push accepted, count becomes 1.
- cpu_data_o = mem[rd_ptr] when count>0, else 0. The new head is visible the cycle after a pop. A pushed byte is visible the cycle after the push (write-through not required).
- cpu_valid_o = (count!=0), registered-equivalent (derived from count register).
- overflow_o: set on dropped byte; cleared by ovf_clr_i. If set and clear occur in the same cycle, set wins.
- Latency: byte on rx_data_i at edge N -> cpu_valid_o/cpu_data_o valid after edge N.
- A pointer-based design with an explicit count register is required. Full/empty come from count, not from pointer compare.

Optional Feature:
- Macro: UART_RX_FIFO_IRQ_EN.
- Defined: irq_o registered, irq_o<=(next_count>=IRQ_LEVEL) || overflow_next. It updates the same edge as count and deasserts once the CPU drains below the level and overflow is cleared.
- Undefined: irq_o tied to 0; IRQ_LEVEL is unused and no irq logic is synthesised.

Decomposition:
- Shared package uart_pkg: UART_DATA_W=8 and MMIO status bit positions (STAT_VALID=0, STAT_OVF=1, STAT_IRQ=2). The UART receiver, transmitter and MMIO decoder use it too.
- Sub-module: sync_fifo_mem (DEPTH x 8 register array, one write port, asynchronous read port). Pointer, count and flag control stay in uart_rx_fifo.

Test Plan:
- Reset mid-fill: push 0x11,0x22, assert rst one cycle -> count_o=0, cpu_valid_o=0, overflow_o=0, cpu_data_o=0; then push 0x33 -> cpu_data_o=0x33, count_o=1.
- In-order drain: push 0xA0..0xA4 via ready/read handshake (ready held until rx_read_o) -> exactly 5 pushes, count_o=5. Pops return A0,A1,A2,A3,A4, then cpu_valid_o=0; a sixth pop leaves count_o=0.
- Wrap-around: DEPTH=16; push 12, pop 12, push 10, pop 10 -> data order preserved across pointer wrap, count_o returns to 0.
- Full/overflow: push 17 bytes 0x00..0x10 with no pops -> count_o=16, overflow_o=1, 0x10 discarded, rx_read_o pulsed on all 17. ovf_clr_i -> overflow_o=0. Set and clear in the same cycle -> overflow_o stays 1.
- Simultaneous events: at full, push 0x55 with cpu_rd_i -> count_o stays 16, no overflow, and 0x55 pops last. At empty, push 0x66 with cpu_rd_i -> count_o=1, head=0x66.
- With UART_RX_FIFO_IRQ_EN defined, IRQ_LEVEL=8: irq_o rises on the edge count reaches 8 and falls when popped to 7. Without the macro, irq_o=0 throughout.
